// File: rtl/drum_playback_scheduler_pkg.sv
// Shared types for the drum playback scheduler: FSM state encoding (3-bit).
package drum_playback_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_WAIT_TIME = 3'd3,
    S_PLAY      = 3'd4,
    S_ACK       = 3'd5,
    S_ADVANCE   = 3'd6
  } state_e;

endpackage

// File: rtl/drum_playback_scheduler.sv
// Walks the drum note RAM from address 0, waits for each record's timestamp on the
// shared microsecond timer and issues one play handshake per record.
module drum_playback_scheduler
  import drum_playback_scheduler_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int TIME_W = 29,
  parameter int ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loopEnable,
  input  logic [ADDR_W-1:0]        noteCount,
  output logic [ADDR_W-1:0]        readAddress,
  input  logic [ID_W+TIME_W-1:0]   readData,
  input  logic [TIME_W-1:0]        microSecondCounter,
  output logic                     timerClear,
  output logic                     playDrumNote,
  output logic [ID_W-1:0]          drumId,
  input  logic                     donePlayingDrumNote,
  output logic                     busy,
  output logic                     loopWrap
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [TIME_W-1:0]   ts_q, ts_d;
  logic                play_q, play_d;
  logic                tclr_q, tclr_d;
  logic                wrap_q, wrap_d;
  logic [ADDR_W:0]     addr_nxt;
  logic                has_next;

  // One extra bit so the last address of a full RAM never wraps before the compare.
  assign addr_nxt = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign has_next = addr_nxt < {1'b0, noteCount};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    ts_d    = ts_q;
    wrap_d  = 1'b0;
    case (state_q)
      S_IDLE:      if (start && (noteCount != '0)) state_d = S_FETCH;
      S_FETCH:     state_d = S_LATCH;
      S_LATCH: begin
        id_d    = readData[ID_W+TIME_W-1:TIME_W];
        ts_d    = readData[TIME_W-1:0];
        state_d = S_WAIT_TIME;
      end
      S_WAIT_TIME: if (microSecondCounter >= ts_q) state_d = S_PLAY;
      S_PLAY:      if (donePlayingDrumNote) state_d = S_ACK;
      S_ACK:       if (!donePlayingDrumNote) state_d = S_ADVANCE;
      S_ADVANCE: begin
        if (has_next) begin
          addr_d  = addr_nxt[ADDR_W-1:0];
          state_d = S_FETCH;
        end else if (loopEnable) begin
          addr_d  = '0;
          wrap_d  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default:     state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
      wrap_d  = 1'b0;
    end
    if (state_d == S_IDLE) addr_d = '0;
    // Outputs are registered from the next state so they change on the same edge.
    play_d = (state_d == S_PLAY);
    tclr_d = (state_d == S_IDLE) || wrap_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      ts_q    <= '0;
      play_q  <= 1'b0;
      tclr_q  <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      play_q  <= play_d;
      tclr_q  <= tclr_d;
      wrap_q  <= wrap_d;
    end
  end

  assign readAddress  = addr_q;
  assign drumId       = id_q;
  assign playDrumNote = play_q;
  assign timerClear   = tclr_q;
  assign loopWrap     = wrap_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_drum_playback_scheduler.sv
// Bench for drum_playback_scheduler: RAM, timer and player models plus a queue of
// expected plays derived from the stored records.
module tb_drum_playback_scheduler;
  localparam int AW = 7;
  localparam int TW = 29;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loopEnable = 1'b0;
  logic [AW-1:0] noteCount = '0;
  logic [AW-1:0] readAddress;
  logic [IW+TW-1:0] readData = '0;
  logic [TW-1:0] usec = '0;
  logic          timerClear, playDrumNote, busy, loopWrap;
  logic          done = 1'b0;
  logic [IW-1:0] drumId;

  always #5 clk = ~clk;

  drum_playback_scheduler #(.ADDR_W(AW), .TIME_W(TW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loopEnable(loopEnable),
    .noteCount(noteCount), .readAddress(readAddress), .readData(readData),
    .microSecondCounter(usec), .timerClear(timerClear), .playDrumNote(playDrumNote),
    .drumId(drumId), .donePlayingDrumNote(done), .busy(busy), .loopWrap(loopWrap)
  );

  logic [IW+TW-1:0] ram [0:127];
  always @(posedge clk) readData <= ram[readAddress];
  always @(posedge clk) usec <= timerClear ? '0 : usec + TW'(1);

  int passed = 0, total = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Player: raises done pdelay cycles into a play, drops it once play falls.
  int pdelay = 5, pcnt = 0;
  always @(negedge clk) begin
    if (playDrumNote && !done) begin
      if (pcnt >= pdelay) begin done = 1'b1; pcnt = 0; end
      else pcnt++;
    end else if (!playDrumNote) begin
      done = 1'b0;
      pcnt = 0;
    end
  end

  int exp_id[$], exp_ts[$];
  bit exp_tight[$];
  int plays = 0, wraps = 0, max_addr = 0;
  bit prev_play = 1'b0;
  logic [IW-1:0] prev_id = '0;
  always @(negedge clk) begin
    if (loopWrap === 1'b1) begin
      wraps++;
      chk("wrap_with_timer_clear", timerClear, 1);
    end
    if (playDrumNote === 1'b1 && !prev_play) begin
      plays++;
      if (int'(readAddress) > max_addr) max_addr = int'(readAddress);
      if (exp_id.size() == 0) chk("unexpected_play", exp_id.size(), 1);
      else begin
        int id, ts;
        bit tight;
        id = exp_id.pop_front(); ts = exp_ts.pop_front(); tight = exp_tight.pop_front();
        chk("play_drum_id", drumId, id);
        chk("play_not_early", (int'(usec) >= ts + 1), 1);
        if (tight) chk("play_exact_time", usec, ts + 1);
      end
    end else if (playDrumNote === 1'b1 && prev_play) begin
      chk("drum_id_stable", drumId, prev_id);
    end
    prev_play = (playDrumNote === 1'b1);
    prev_id   = drumId;
  end

  // Expected plays of one pass: records in address order; a record whose timestamp
  // is well past the previous one must fire exactly one tick after the timer hits it.
  task automatic expect_pass(int n);
    int prev;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      int ts;
      ts = int'(ram[i][TW-1:0]);
      exp_id.push_back(int'(ram[i][IW+TW-1:TW]));
      exp_ts.push_back(ts);
      exp_tight.push_back(ts >= 30 && (ts - prev) >= 30);
      prev = ts;
    end
  endtask

  task automatic clear_expect();
    exp_id.delete(); exp_ts.delete(); exp_tight.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic wait_idle(int budget, string nm);
    int c;
    c = 0;
    while (busy && c < budget) begin @(negedge clk); c++; end
    chk(nm, busy, 0);
  endtask

  task automatic wait_plays(int n, int budget, string nm);
    int c;
    c = 0;
    while (plays < n && c < budget) begin @(negedge clk); c++; end
    chk(nm, (plays >= n), 1);
  endtask

  task automatic wait_play_high(int budget, string nm);
    int c;
    c = 0;
    while (!playDrumNote && c < budget) begin @(negedge clk); c++; end
    chk(nm, playDrumNote, 1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 128; i++) ram[i] = '0;
    ram[0] = {2'd0, 29'd0};
    ram[1] = {2'd1, 29'd100};
    ram[2] = {2'd3, 29'd250};
  endtask

  typedef struct {
    bit st; bit sp; int n; bit exp_busy; bit exp_tclr;
  } vec_t;

  initial begin
    vec_t vecs[5];
    vecs[0] = '{st: 1, sp: 0, n: 0, exp_busy: 0, exp_tclr: 1};
    vecs[1] = '{st: 1, sp: 1, n: 3, exp_busy: 0, exp_tclr: 1};
    vecs[2] = '{st: 0, sp: 1, n: 3, exp_busy: 0, exp_tclr: 1};
    vecs[3] = '{st: 1, sp: 0, n: 3, exp_busy: 1, exp_tclr: 0};
    vecs[4] = '{st: 0, sp: 0, n: 5, exp_busy: 0, exp_tclr: 1};
    load_basic();

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_timer_clear", timerClear, 1);
    chk("reset_play", playDrumNote, 0);
    chk("reset_addr", readAddress, 0);
    chk("reset_drum_id", drumId, 0);
    chk("reset_loop_wrap", loopWrap, 0);
    reset = 1'b0;

    // IDLE start/stop vectors
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = vecs[i].st; stop = vecs[i].sp; noteCount = AW'(vecs[i].n);
      @(posedge clk); #1;
      chk("vec_busy", busy, vecs[i].exp_busy);
      chk("vec_timer_clear", timerClear, vecs[i].exp_tclr);
      chk("vec_addr", readAddress, 0);
      @(negedge clk); start = 1'b0; stop = 1'b1;
      @(negedge clk); stop = 1'b0;
    end

    // Basic three records with start latency and a start while busy
    noteCount = 3; pdelay = 5; plays = 0; wraps = 0;
    clear_expect(); expect_pass(3);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    chk("e0_busy", busy, 1);
    chk("e0_timer_clear", timerClear, 0);
    @(negedge clk) start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("e3_play", playDrumNote, 1);
    wait_plays(1, 100, "basic_first_play");
    pulse_start();
    wait_idle(2000, "basic_done_idle");
    chk("basic_play_count", plays, 3);
    chk("basic_queue_empty", exp_id.size(), 0);
    chk("basic_idle_addr", readAddress, 0);
    chk("basic_idle_timer_clear", timerClear, 1);

    // Loop restart
    loopEnable = 1'b1; plays = 0; wraps = 0;
    clear_expect(); expect_pass(3); expect_pass(3);
    pulse_start();
    wait_plays(4, 3000, "loop_fourth_play");
    chk("loop_wrap_count", wraps, 1);
    pulse_stop();
    chk("loop_stopped", busy, 0);
    loopEnable = 1'b0; clear_expect();

    // Stop mid-handshake
    plays = 0; expect_pass(3);
    pulse_start();
    wait_play_high(100, "stop_play_seen");
    @(negedge clk) stop = 1'b1;
    @(posedge clk); #1;
    chk("stop_play_low", playDrumNote, 0);
    chk("stop_busy_low", busy, 0);
    chk("stop_addr_zero", readAddress, 0);
    @(negedge clk) stop = 1'b0;
    clear_expect();

    // Full RAM, immediate player response
    for (int i = 0; i < 128; i++) ram[i] = {IW'(i % 4), TW'(0)};
    noteCount = 127; pdelay = 0; plays = 0; max_addr = 0;
    clear_expect(); expect_pass(127);
    pulse_start();
    wait_idle(5000, "full_done_idle");
    chk("full_play_count", plays, 127);
    chk("full_last_addr", max_addr, 126);
    chk("full_idle_addr", readAddress, 0);
    clear_expect();

    // Reset mid-play
    load_basic(); noteCount = 3; pdelay = 5;
    expect_pass(3);
    pulse_start();
    wait_play_high(100, "rst_play_seen");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_play", playDrumNote, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timer_clear", timerClear, 1);
    chk("rst_addr", readAddress, 0);
    chk("rst_drum_id", drumId, 0);
    chk("rst_loop_wrap", loopWrap, 0);
    @(negedge clk) reset = 1'b0;
    clear_expect();

    // Randomized record sets
    for (int it = 0; it < 6; it++) begin
      int n, ts;
      bit lp;
      n = $urandom_range(1, 6);
      ts = 0;
      for (int i = 0; i < n; i++) begin
        ts += $urandom_range(30, 60);
        ram[i] = {IW'($urandom_range(0, 3)), TW'(ts)};
      end
      lp = bit'($urandom_range(0, 1));
      loopEnable = lp; noteCount = AW'(n); pdelay = $urandom_range(0, 6);
      plays = 0; wraps = 0;
      clear_expect(); expect_pass(n);
      if (lp) expect_pass(n);
      pulse_start();
      if (lp) begin
        wait_plays(n + 1, 4000, "rand_loop_plays");
        chk("rand_loop_wraps", wraps, 1);
        pulse_stop();
        chk("rand_loop_stopped", busy, 0);
      end else begin
        wait_idle(4000, "rand_done_idle");
        chk("rand_play_count", plays, n);
        chk("rand_wraps", wraps, 0);
      end
      loopEnable = 1'b0;
      clear_expect();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
